// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the pipeline front end (master) and the PC sequencer (slave).
// Carries the control requests in and the registered PC state out.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                halt_req;
    logic                trap_req;
    logic [PC_WIDTH-1:0] pc_out;
    logic [PC_WIDTH-1:0] pc_next;
    logic                pc_valid;
    logic                misaligned;
    logic [PC_WIDTH-1:0] epc;

    modport master (
        output stall, redirect_valid, redirect_pc, halt_req, trap_req,
        input  pc_out, pc_next, pc_valid, misaligned, epc
    );

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt_req, trap_req,
        output pc_out, pc_next, pc_valid, misaligned, epc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT -> RUN -> HALT sequencing with stall, redirect and wrap.
// Optional trap vector and epc register are enabled by defining PC_TRAP_EN.
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned         INSTR_BYTES  = 4,
    parameter int unsigned         BOOT_CYCLES  = 1,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 'h80
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned         BW         = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0]       BOOT_LAST  = BW'(BOOT_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

`ifdef PC_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t              state_q, state_nxt;
    logic [BW-1:0]       boot_cnt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic                valid_q, valid_nxt;
    logic                mis_q, mis_nxt;
    logic                trap_take;

    assign trap_take = TRAP_EN && bus.trap_req && (state_q != BOOT);

    always_comb begin
        pc_nxt    = pc_q;
        state_nxt = state_q;
        valid_nxt = valid_q;
        mis_nxt   = mis_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = RUN;
                    valid_nxt = 1'b1;
                end
            end
            // RUN and HALT share the trap/redirect exits; halt and stall only matter in RUN
            RUN, HALT: begin
                if (trap_take) begin
                    pc_nxt    = TRAP_VECTOR;
                    state_nxt = RUN;
                    valid_nxt = 1'b1;
                end else if (bus.redirect_valid) begin
                    pc_nxt    = bus.redirect_pc & ~ALIGN_MASK;
                    mis_nxt   = |(bus.redirect_pc & ALIGN_MASK);
                    state_nxt = RUN;
                    valid_nxt = 1'b1;
                end else if (state_q == RUN && bus.halt_req) begin
                    state_nxt = HALT;
                    valid_nxt = 1'b0;
                end else if (state_q == RUN && !bus.stall) begin
                    pc_nxt = pc_q + INC;
                end
            end
            default: begin
                state_nxt = BOOT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            boot_cnt <= '0;
            pc_q     <= RESET_VECTOR;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            valid_q <= valid_nxt;
            mis_q   <= mis_nxt;
            if (state_q == BOOT && boot_cnt != BOOT_LAST)
                boot_cnt <= boot_cnt + BW'(1);
        end
    end

`ifdef PC_TRAP_EN
    logic [PC_WIDTH-1:0] epc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            epc_q <= '0;
        else if (trap_take)
            epc_q <= pc_q;
    end

    assign bus.epc = epc_q;
`else
    assign bus.epc = '0;
`endif

    assign bus.pc_out     = pc_q;
    assign bus.pc_next    = pc_nxt;
    assign bus.pc_valid   = valid_q;
    assign bus.misaligned = mis_q;
endmodule
